// File: rtl/execute_stage.sv
// -----------------------------------------------------------------------------
// execute_stage
// Execute (EX) stage of the 16-bit pipelined core. Applies operand forwarding,
// computes the ALU result and flags, and registers the result, store data and
// memory/writeback controls for the downstream data-memory stage.
//
// Optional feature macro: EX_MUL_EN
//   defined   : op 10 (MUL) runs on a 16-cycle shift-add multiplier. The stage
//               stalls upstream (stall_ex) while the multiplier is busy.
//   undefined : no multiplier/FSM; op 10 is a NOP and stall_ex is tied low.
//
// Ports
//   clk, reset                      clock (rising edge), async active-high reset
//   valid_rr                        upstream presents an instruction
//   alu_op_rr                       ALU operation select
//   a_rr, b_rr, imm_rr, imm_sel_rr  register operands and immediate
//   fwd_sel_a, fwd_sel_b, ans_dm    forwarding selects and DM-stage result
//   mem_rw_rr, mem_en_rr,
//   mem_mux_sel_rr, wb_en_rr, rd_rr controls passed through the stage
//   ans_ex, DM_data                 registered result/address and store data
//   mem_rw_ex, mem_en_ex,
//   mem_mux_sel_dm, wb_en_ex, rd_ex registered controls
//   flags_ex                        {Z,N,C,V}
//   stall_ex                        upstream must hold its inputs while high
// -----------------------------------------------------------------------------
module execute_stage #(
    parameter int DATA_W = 16,
    parameter int RD_W   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_rr,
    input  logic [3:0]        alu_op_rr,
    input  logic [DATA_W-1:0] a_rr,
    input  logic [DATA_W-1:0] b_rr,
    input  logic [DATA_W-1:0] imm_rr,
    input  logic              imm_sel_rr,
    input  logic [1:0]        fwd_sel_a,
    input  logic [1:0]        fwd_sel_b,
    input  logic [DATA_W-1:0] ans_dm,
    input  logic              mem_rw_rr,
    input  logic              mem_en_rr,
    input  logic              mem_mux_sel_rr,
    input  logic              wb_en_rr,
    input  logic [RD_W-1:0]   rd_rr,
    output logic [DATA_W-1:0] ans_ex,
    output logic [DATA_W-1:0] DM_data,
    output logic              mem_rw_ex,
    output logic              mem_en_ex,
    output logic              mem_mux_sel_dm,
    output logic              wb_en_ex,
    output logic [RD_W-1:0]   rd_ex,
    output logic [3:0]        flags_ex,
    output logic              stall_ex
);
    localparam int MSB = DATA_W - 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_ASR  = 4'd8;
    localparam logic [3:0] OP_PASS = 4'd9;

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b_fwd;   // forwarded B, also the store data
    logic [DATA_W-1:0] op_b;       // ALU operand B after the immediate mux
    logic [DATA_W:0]   sum_ext;
    logic [DATA_W-1:0] diff;
    logic [DATA_W-1:0] alu_res;
    logic              c_next;
    logic              v_next;
    logic              upd_zn;
    logic              upd_cv;
    logic              accept_alu;

    // Forwarding: selection 1 takes this stage's own registered result so a
    // back-to-back dependent instruction sees it without a bubble.
    always_comb begin
        case (fwd_sel_a)
            2'd1:    op_a = ans_ex;
            2'd2:    op_a = ans_dm;
            default: op_a = a_rr;
        endcase
        case (fwd_sel_b)
            2'd1:    op_b_fwd = ans_ex;
            2'd2:    op_b_fwd = ans_dm;
            default: op_b_fwd = b_rr;
        endcase
    end

    assign op_b    = imm_sel_rr ? imm_rr : op_b_fwd;
    assign sum_ext = {1'b0, op_a} + {1'b0, op_b};
    assign diff    = op_a - op_b;

    always_comb begin
        alu_res = '0;
        c_next  = 1'b0;
        v_next  = 1'b0;
        upd_zn  = 1'b0;
        upd_cv  = 1'b0;
        case (alu_op_rr)
            OP_ADD: begin
                alu_res = sum_ext[MSB:0];
                c_next  = sum_ext[DATA_W];
                v_next  = (op_a[MSB] == op_b[MSB]) && (sum_ext[MSB] != op_a[MSB]);
                upd_zn  = 1'b1;
                upd_cv  = 1'b1;
            end
            OP_SUB: begin
                alu_res = diff;
                c_next  = (op_a >= op_b);  // carry = no borrow
                v_next  = (op_a[MSB] != op_b[MSB]) && (diff[MSB] != op_a[MSB]);
                upd_zn  = 1'b1;
                upd_cv  = 1'b1;
            end
            OP_AND:  begin alu_res = op_a & op_b;         upd_zn = 1'b1; end
            OP_OR:   begin alu_res = op_a | op_b;         upd_zn = 1'b1; end
            OP_XOR:  begin alu_res = op_a ^ op_b;         upd_zn = 1'b1; end
            OP_NOT:  begin alu_res = ~op_a;               upd_zn = 1'b1; end
            OP_SHL:  begin alu_res = op_a << op_b[3:0];   upd_zn = 1'b1; end
            OP_SHR:  begin alu_res = op_a >> op_b[3:0];   upd_zn = 1'b1; end
            OP_ASR:  begin alu_res = DATA_W'($signed(op_a) >>> op_b[3:0]); upd_zn = 1'b1; end
            OP_PASS: begin alu_res = op_b;                upd_zn = 1'b1; end
            // MUL (when enabled) is completed by the FSM; everything else is a
            // NOP that registers a zero result and leaves the flags alone.
            default: ;
        endcase
    end

`ifdef EX_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd10;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t            state_reg;
    logic [3:0]        mul_cnt_reg;
    logic [DATA_W-1:0] mul_acc_reg;
    logic [DATA_W-1:0] mul_acc_next;
    logic [DATA_W-1:0] mul_mcand_reg;
    logic [DATA_W-1:0] mul_mplier_reg;
    logic [DATA_W-1:0] mul_dm_reg;
    logic [RD_W-1:0]   mul_rd_reg;
    logic [3:0]        mul_ctl_reg;   // {mem_en, mem_rw, mem_mux_sel, wb_en}
    logic              is_mul;

    assign is_mul       = (alu_op_rr == OP_MUL);
    assign accept_alu   = valid_rr && (state_reg == IDLE) && !is_mul;
    assign stall_ex     = (state_reg == BUSY);
    // Only the low DATA_W bits of the product are kept, so the multiplicand
    // is simply shifted left and allowed to fall off the top.
    assign mul_acc_next = mul_acc_reg + (mul_mplier_reg[0] ? mul_mcand_reg : '0);
`else
    assign accept_alu = valid_rr;
    assign stall_ex   = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ans_ex         <= '0;
            DM_data        <= '0;
            mem_rw_ex      <= 1'b0;
            mem_en_ex      <= 1'b0;
            mem_mux_sel_dm <= 1'b0;
            wb_en_ex       <= 1'b0;
            rd_ex          <= '0;
            flags_ex       <= '0;
`ifdef EX_MUL_EN
            state_reg      <= IDLE;
            mul_cnt_reg    <= '0;
            mul_acc_reg    <= '0;
            mul_mcand_reg  <= '0;
            mul_mplier_reg <= '0;
            mul_dm_reg     <= '0;
            mul_rd_reg     <= '0;
            mul_ctl_reg    <= '0;
`endif
        end else begin
            // Bubble by default: side-effecting controls drop, the rest hold.
            mem_rw_ex <= 1'b0;
            mem_en_ex <= 1'b0;
            wb_en_ex  <= 1'b0;

            if (accept_alu) begin
                ans_ex         <= alu_res;
                DM_data        <= op_b_fwd;
                mem_rw_ex      <= mem_rw_rr;
                mem_en_ex      <= mem_en_rr;
                mem_mux_sel_dm <= mem_mux_sel_rr;
                wb_en_ex       <= wb_en_rr;
                rd_ex          <= rd_rr;
                if (upd_zn) begin
                    flags_ex[3] <= (alu_res == '0);
                    flags_ex[2] <= alu_res[MSB];
                end
                if (upd_cv) begin
                    flags_ex[1] <= c_next;
                    flags_ex[0] <= v_next;
                end
            end

`ifdef EX_MUL_EN
            case (state_reg)
                IDLE: begin
                    if (valid_rr && is_mul) begin
                        state_reg      <= BUSY;
                        mul_cnt_reg    <= '0;
                        mul_acc_reg    <= '0;
                        mul_mcand_reg  <= op_a;
                        mul_mplier_reg <= op_b;
                        mul_dm_reg     <= op_b_fwd;
                        mul_rd_reg     <= rd_rr;
                        mul_ctl_reg    <= {mem_en_rr, mem_rw_rr, mem_mux_sel_rr, wb_en_rr};
                    end
                end
                BUSY: begin
                    mul_acc_reg    <= mul_acc_next;
                    mul_mcand_reg  <= mul_mcand_reg << 1;
                    mul_mplier_reg <= mul_mplier_reg >> 1;
                    mul_cnt_reg    <= mul_cnt_reg + 4'd1;
                    if (mul_cnt_reg == 4'd15) begin
                        state_reg      <= IDLE;
                        ans_ex         <= mul_acc_next;
                        DM_data        <= mul_dm_reg;
                        rd_ex          <= mul_rd_reg;
                        mem_en_ex      <= mul_ctl_reg[3];
                        mem_rw_ex      <= mul_ctl_reg[2];
                        mem_mux_sel_dm <= mul_ctl_reg[1];
                        wb_en_ex       <= mul_ctl_reg[0];
                        flags_ex[3]    <= (mul_acc_next == '0);
                        flags_ex[2]    <= mul_acc_next[MSB];
                    end
                end
                default: state_reg <= IDLE;
            endcase
`endif
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;
    logic        clk;
    logic        reset;
    logic        valid_rr;
    logic [3:0]  alu_op_rr;
    logic [15:0] a_rr, b_rr, imm_rr, ans_dm;
    logic        imm_sel_rr;
    logic [1:0]  fwd_sel_a, fwd_sel_b;
    logic        mem_rw_rr, mem_en_rr, mem_mux_sel_rr, wb_en_rr;
    logic [2:0]  rd_rr;
    logic [15:0] ans_ex, DM_data;
    logic        mem_rw_ex, mem_en_ex, mem_mux_sel_dm, wb_en_ex;
    logic [2:0]  rd_ex;
    logic [3:0]  flags_ex;
    logic        stall_ex;

    int checks   = 0;
    int failures = 0;

    execute_stage #(.DATA_W(16), .RD_W(3)) dut (
        .clk(clk), .reset(reset), .valid_rr(valid_rr), .alu_op_rr(alu_op_rr),
        .a_rr(a_rr), .b_rr(b_rr), .imm_rr(imm_rr), .imm_sel_rr(imm_sel_rr),
        .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .ans_dm(ans_dm),
        .mem_rw_rr(mem_rw_rr), .mem_en_rr(mem_en_rr),
        .mem_mux_sel_rr(mem_mux_sel_rr), .wb_en_rr(wb_en_rr), .rd_rr(rd_rr),
        .ans_ex(ans_ex), .DM_data(DM_data), .mem_rw_ex(mem_rw_ex),
        .mem_en_ex(mem_en_ex), .mem_mux_sel_dm(mem_mux_sel_dm),
        .wb_en_ex(wb_en_ex), .rd_ex(rd_ex), .flags_ex(flags_ex),
        .stall_ex(stall_ex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctl fields are packed {mem_en, mem_rw, mem_mux_sel, wb_en}
    typedef struct {
        logic        valid;
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] imm;
        logic        isel;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [15:0] adm;
        logic [3:0]  ctl;
        logic [2:0]  rd;
        logic [15:0] e_ans;
        logic [15:0] e_dm;
        logic [3:0]  e_flags;
        logic [3:0]  e_ctl;
        logic [2:0]  e_rd;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];
    vec_t t;

    task automatic check(input string name, input int idx,
                         input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%h expected=%h", name, idx, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        valid_rr       = v.valid;
        alu_op_rr      = v.op;
        a_rr           = v.a;
        b_rr           = v.b;
        imm_rr         = v.imm;
        imm_sel_rr     = v.isel;
        fwd_sel_a      = v.fa;
        fwd_sel_b      = v.fb;
        ans_dm         = v.adm;
        mem_en_rr      = v.ctl[3];
        mem_rw_rr      = v.ctl[2];
        mem_mux_sel_rr = v.ctl[1];
        wb_en_rr       = v.ctl[0];
        rd_rr          = v.rd;
    endtask

    task automatic check_outputs(input string name, input int idx, input vec_t v);
        check({name, "_ans"},   idx, 32'(ans_ex),   32'(v.e_ans));
        check({name, "_dm"},    idx, 32'(DM_data),  32'(v.e_dm));
        check({name, "_flags"}, idx, 32'(flags_ex), 32'(v.e_flags));
        check({name, "_ctl"},   idx, 32'({mem_en_ex, mem_rw_ex, mem_mux_sel_dm, wb_en_ex}), 32'(v.e_ctl));
        check({name, "_rd"},    idx, 32'(rd_ex),    32'(v.e_rd));
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ans"},   0, 32'(ans_ex),   32'h0);
        check({name, "_dm"},    0, 32'(DM_data),  32'h0);
        check({name, "_flags"}, 0, 32'(flags_ex), 32'h0);
        check({name, "_ctl"},   0, 32'({mem_en_ex, mem_rw_ex, mem_mux_sel_dm, wb_en_ex, rd_ex}), 32'h0);
        check({name, "_stall"}, 0, 32'(stall_ex), 32'h0);
    endtask

    // Global watchdog so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        //               v  op  a         b         imm       is fa    fb    adm       ctl      rd     ans       dm        flags    ctl      rd
        vecs[0]  = '{1'b1, 4'd0, 16'h7FFF, 16'h0001, 16'h0000, 1'b0, 2'd0, 2'd0, 16'h0000, 4'b0001, 3'd1, 16'h8000, 16'h0001, 4'b0101, 4'b0001, 3'd1};
        vecs[1]  = '{1'b1, 4'd1, 16'h0003, 16'h0003, 16'h0000, 1'b0, 2'd0, 2'd0, 16'h0000, 4'b0001, 3'd2, 16'h0000, 16'h0003, 4'b1010, 4'b0001, 3'd2};
        vecs[2]  = '{1'b1, 4'd2, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 2'd1, 2'd0, 16'h0000, 4'b0001, 3'd3, 16'h0000, 16'hFFFF, 4'b1010, 4'b0001, 3'd3};
        vecs[3]  = '{1'b1, 4'd0, 16'h0003, 16'hFFFF, 16'h0000, 1'b1, 2'd0, 2'd0, 16'h0000, 4'b1100, 3'd0, 16'h0003, 16'hFFFF, 4'b0000, 4'b1100, 3'd0};
        vecs[4]  = '{1'b0, 4'd0, 16'h0001, 16'h0001, 16'h0000, 1'b0, 2'd0, 2'd0, 16'h0000, 4'b1111, 3'd7, 16'h0003, 16'hFFFF, 4'b0000, 4'b0000, 3'd0};
        vecs[5]  = '{1'b1, 4'd1, 16'h0001, 16'h0002, 16'h0000, 1'b0, 2'd0, 2'd0, 16'h0000, 4'b1011, 3'd4, 16'hFFFF, 16'h0002, 4'b0100, 4'b1011, 3'd4};
        vecs[6]  = '{1'b0, 4'd0, 16'h0001, 16'h0001, 16'h0000, 1'b0, 2'd0, 2'd0, 16'h0000, 4'b1101, 3'd1, 16'hFFFF, 16'h0002, 4'b0100, 4'b0010, 3'd4};
        vecs[7]  = '{1'b1, 4'd1, 16'h8000, 16'h0001, 16'h0000, 1'b0, 2'd0, 2'd0, 16'h0000, 4'b0001, 3'd5, 16'h7FFF, 16'h0001, 4'b0011, 4'b0001, 3'd5};
        vecs[8]  = '{1'b1, 4'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 2'd0, 2'd0, 16'h0000, 4'b0001, 3'd6, 16'h0000, 16'h0001, 4'b1010, 4'b0001, 3'd6};
        vecs[9]  = '{1'b1, 4'd3, 16'h0F00, 16'h1234, 16'h0000, 1'b0, 2'd0, 2'd2, 16'h00F0, 4'b0001, 3'd7, 16'h0FF0, 16'h00F0, 4'b0010, 4'b0001, 3'd7};
        vecs[10] = '{1'b1, 4'd4, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 2'd1, 2'd0, 16'h0000, 4'b0001, 3'd1, 16'hF00F, 16'hFFFF, 4'b0110, 4'b0001, 3'd1};
        vecs[11] = '{1'b1, 4'd5, 16'h00FF, 16'h0000, 16'h0000, 1'b0, 2'd0, 2'd0, 16'h0000, 4'b0001, 3'd2, 16'hFF00, 16'h0000, 4'b0110, 4'b0001, 3'd2};
        vecs[12] = '{1'b1, 4'd6, 16'h0001, 16'h000F, 16'h0000, 1'b0, 2'd0, 2'd0, 16'h0000, 4'b0001, 3'd3, 16'h8000, 16'h000F, 4'b0110, 4'b0001, 3'd3};
        vecs[13] = '{1'b1, 4'd7, 16'h8000, 16'h0004, 16'h0000, 1'b0, 2'd0, 2'd0, 16'h0000, 4'b0001, 3'd4, 16'h0800, 16'h0004, 4'b0010, 4'b0001, 3'd4};
        vecs[14] = '{1'b1, 4'd8, 16'h8000, 16'h0014, 16'h0000, 1'b0, 2'd0, 2'd0, 16'h0000, 4'b0001, 3'd5, 16'hF800, 16'h0014, 4'b0110, 4'b0001, 3'd5};
        vecs[15] = '{1'b1, 4'd6, 16'h1234, 16'h0010, 16'h0000, 1'b0, 2'd0, 2'd0, 16'h0000, 4'b0001, 3'd6, 16'h1234, 16'h0010, 4'b0010, 4'b0001, 3'd6};
        vecs[16] = '{1'b1, 4'd9, 16'h0000, 16'h0005, 16'hFFFE, 1'b1, 2'd0, 2'd0, 16'h0000, 4'b0001, 3'd7, 16'hFFFE, 16'h0005, 4'b0110, 4'b0001, 3'd7};
        vecs[17] = '{1'b1, 4'd12,16'h0005, 16'h0006, 16'h0000, 1'b0, 2'd0, 2'd0, 16'h0000, 4'b0001, 3'd3, 16'h0000, 16'h0006, 4'b0110, 4'b0001, 3'd3};
        vecs[18] = '{1'b1, 4'd0, 16'h4000, 16'h4000, 16'h0000, 1'b0, 2'd3, 2'd3, 16'h0000, 4'b0001, 3'd2, 16'h8000, 16'h4000, 4'b0101, 4'b0001, 3'd2};
        vecs[19] = '{1'b1, 4'd0, 16'h0001, 16'h0009, 16'h0000, 1'b0, 2'd0, 2'd2, 16'h0010, 4'b0001, 3'd1, 16'h0011, 16'h0010, 4'b0000, 4'b0001, 3'd1};
        vecs[20] = '{1'b1, 4'd1, 16'h0020, 16'h7777, 16'h0005, 1'b1, 2'd0, 2'd1, 16'h0000, 4'b0001, 3'd0, 16'h001B, 16'h0011, 4'b0010, 4'b0001, 3'd0};

        // Idle inputs, reset asserted across two edges.
        t = '{1'b0, 4'd0, 16'h0, 16'h0, 16'h0, 1'b0, 2'd0, 2'd0, 16'h0, 4'b0000, 3'd0,
              16'h0, 16'h0, 4'b0000, 4'b0000, 3'd0};
        drive(t);
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all_zero("reset_init");
        @(negedge clk);
        reset = 1'b0;

        // Table-driven vectors, back-to-back so fwd_sel=1 sees the previous result.
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            @(posedge clk);
            #1;
            $display("vec %0d valid=%0d op=%0d ans_ex=%h DM_data=%h flags=%b", i,
                     vecs[i].valid, vecs[i].op, ans_ex, DM_data, flags_ex);
            check_outputs("vec", i, vecs[i]);
        end

        // Asynchronous reset mid-stream: outputs clear before any clock edge.
        @(negedge clk);
        t.valid = 1'b0;
        drive(t);
        #1;
        reset = 1'b1;
        #1;
        $display("async reset mid-stream ans_ex=%h stall_ex=%0d", ans_ex, stall_ex);
        check_all_zero("reset_async");
        @(negedge clk);
        reset = 1'b0;

        // Preload: SUB 5-1 -> ans 4, flags C=1.
        @(negedge clk);
        t = '{1'b1, 4'd1, 16'h0005, 16'h0001, 16'h0, 1'b0, 2'd0, 2'd0, 16'h0, 4'b0001, 3'd6,
              16'h0004, 16'h0001, 4'b0010, 4'b0001, 3'd6};
        drive(t);
        @(posedge clk);
        #1;
        $display("preload sub ans_ex=%h flags=%b", ans_ex, flags_ex);
        check_outputs("preload", 0, t);

`ifdef EX_MUL_EN
        // MUL 0x12 * 0x34, then a held ADD.
        @(negedge clk);
        t = '{1'b1, 4'd10, 16'h0012, 16'h0034, 16'h0, 1'b0, 2'd0, 2'd0, 16'h0, 4'b0001, 3'd2,
              16'h03A8, 16'h0034, 4'b0010, 4'b0001, 3'd2};
        drive(t);
        @(posedge clk);
        #1;
        check("mul_accept_stall", 0, 32'(stall_ex), 32'h1);
        check("mul_accept_bubble_wb", 0, 32'(wb_en_ex), 32'h0);
        check("mul_accept_ans_hold", 0, 32'(ans_ex), 32'h0004);
        @(negedge clk);
        drive('{1'b1, 4'd0, 16'h0001, 16'h0002, 16'h0, 1'b0, 2'd0, 2'd0, 16'h0, 4'b0001, 3'd5,
                16'h0, 16'h0, 4'b0000, 4'b0000, 3'd0});
        n = 0;
        while (stall_ex && n < 40) begin
            n++;
            @(posedge clk);
            #1;
        end
        $display("mul done stall_cycles=%0d ans_ex=%h flags=%b", n, ans_ex, flags_ex);
        check("mul_stall_cycles", 0, 32'(n), 32'd16);
        check_outputs("mul_result", 0, t);
        @(posedge clk);
        #1;
        $display("held add ans_ex=%h flags=%b", ans_ex, flags_ex);
        check("held_add_ans", 0, 32'(ans_ex), 32'h0003);
        check("held_add_flags", 0, 32'(flags_ex), 32'h0);
        check("held_add_ctl", 0, 32'({wb_en_ex, rd_ex}), 32'({1'b1, 3'd5}));
        check("held_add_stall", 0, 32'(stall_ex), 32'h0);

        // MUL aborted by reset at busy cycle 5.
        @(negedge clk);
        drive('{1'b1, 4'd10, 16'h0012, 16'h0034, 16'h0, 1'b0, 2'd0, 2'd0, 16'h0, 4'b0001, 3'd2,
                16'h0, 16'h0, 4'b0000, 4'b0000, 3'd0});
        @(posedge clk);
        for (int k = 0; k < 5; k++) @(posedge clk);
        @(negedge clk);
        check("abort_busy_before_reset", 0, 32'(stall_ex), 32'h1);
        reset = 1'b1;
        #1;
        $display("mul abort reset stall_ex=%0d ans_ex=%h", stall_ex, ans_ex);
        check("abort_stall", 0, 32'(stall_ex), 32'h0);
        check("abort_ans", 0, 32'(ans_ex), 32'h0);
        drive('{1'b1, 4'd0, 16'h0002, 16'h0003, 16'h0, 1'b0, 2'd0, 2'd0, 16'h0, 4'b0001, 3'd1,
                16'h0, 16'h0, 4'b0000, 4'b0000, 3'd0});
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        $display("post-abort add ans_ex=%h", ans_ex);
        check("post_abort_ans", 0, 32'(ans_ex), 32'h0005);
        check("post_abort_stall", 0, 32'(stall_ex), 32'h0);
`else
        // Without the multiplier, op 10 is a single-cycle NOP.
        @(negedge clk);
        t = '{1'b1, 4'd10, 16'h0012, 16'h0034, 16'h0, 1'b0, 2'd0, 2'd0, 16'h0, 4'b0001, 3'd2,
              16'h0000, 16'h0034, 4'b0010, 4'b0001, 3'd2};
        drive(t);
        n = 0;
        @(posedge clk);
        #1;
        $display("mul-as-nop ans_ex=%h flags=%b stall_ex=%0d", ans_ex, flags_ex, stall_ex);
        check_outputs("mul_nop", 0, t);
        @(negedge clk);
        t.valid = 1'b0;
        drive(t);
        for (int k = 0; k < 20; k++) begin
            if (stall_ex) n++;
            @(negedge clk);
        end
        check("mul_nop_stall_cycles", 0, 32'(n), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute (EX) stage of the 16-bit pipelined core; sits directly upstream of the data-memory stage.
- Takes register-read operands and control, applies operand forwarding, and computes the ALU result.
- Registers ans_ex, DM_data and memory controls for the data-memory stage.
- Holds a Z/N/C/V flag register and an optional 16-cycle shift-add multiplier that stalls upstream.

Parameters:
DATA_W, 16, operand/result width (the design is verified at 16 only).
RD_W, 3, destination register address width.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  reset; asynchronous, active-high.
valid_rr  in  1  register-read stage presents an instruction.
alu_op_rr  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL, 7 SHR logical, 8 ASR, 9 PASS B, 10 MUL, 11-15 NOP.
a_rr  in  DATA_W  register operand A.
b_rr  in  DATA_W  register operand B; also the store data.
imm_rr  in  DATA_W  sign-extended immediate.
imm_sel_rr  in  1  1: ALU operand B = imm_rr.
fwd_sel_a  in  2  0 a_rr, 1 ans_ex, 2 ans_dm, 3 a_rr.
fwd_sel_b  in  2  same encoding, applied to b_rr.
ans_dm  in  DATA_W  data-memory stage result, used for forwarding.
mem_rw_rr, mem_en_rr, mem_mux_sel_rr, wb_en_rr  in  1 each  controls passed through the stage.
rd_rr  in  RD_W  destination register.
ans_ex  out  DATA_W  registered ALU result / memory address.
DM_data  out  DATA_W  registered store data (forwarded B, before the immediate mux).
mem_rw_ex, mem_en_ex, mem_mux_sel_dm, wb_en_ex  out  1 each  registered controls.
rd_ex  out  RD_W  registered destination register.
flags_ex  out  4  {Z,N,C,V}.
stall_ex  out  1  upstream must hold its inputs while high.

Behaviour:
- Reset (asynchronous, any time, including mid-multiply):
  - All outputs and flags go to 0; FSM goes to IDLE; multiply is aborted.
  - First edge after deassertion operates normally.
- Accept condition: valid_rr=1 and state=IDLE. Accepted non-MUL instructions take 1 cycle; outputs update on the next edge.
- Bubble (no accept):
  - mem_en_ex=0, mem_rw_ex=0, wb_en_ex=0.
  - ans_ex, DM_data, rd_ex, mem_mux_sel_dm and flags hold.
- Forwarding:
  - Applied before the immediate mux.
  - Selection 1 uses the current registered ans_ex, i.e. back-to-back dependence.
- Arithmetic (all results truncated to DATA_W):
  - ADD: C = carry out.
  - SUB: computes A-B; C = 1 when A >= B unsigned (no borrow).
  - V = signed overflow.
  - Shifts use B[3:0]; a shift amount of 0 returns A.
- Flag updates:
  - ADD and SUB update Z, N, C, V.
  - Ops 2-10 update Z and N only; C and V hold.
  - NOP: ans_ex=0, flags hold, passed-through controls still registered.
- FSM states: IDLE, BUSY.
  - IDLE -> BUSY on an accepted MUL. Operands and controls are latched; count=0.
  - On the accept edge, outputs take the bubble values.
  - BUSY: one shift-add iteration per edge. stall_ex=1 (stall_ex is a pure function of state).
  - On the 16th BUSY edge: ans_ex = product[15:0]; latched controls are applied; Z/N are updated; state -> IDLE.
  - stall_ex is high for exactly 16 cycles.
  - valid_rr is ignored while BUSY; the held instruction is accepted on the first IDLE edge.
  - fwd_sel=1 during a multiply is not allowed (upstream interlock guarantees this).

Optional Feature:
EX_MUL_EN
- Defined: MUL is implemented as described above.
- Undefined:
  - No multiplier or FSM logic; stall_ex is tied to 0.
  - Op 10 behaves as NOP: ans_ex=0, flags hold, 1-cycle latency.

Test Plan:
- Reset pulse mid-stream -> every output and flags_ex read 0 immediately, before any clock edge; stall_ex=0.
- ADD a=16'h7FFF, b=16'h0001 -> next edge: ans_ex=16'h8000, flags N=1, V=1, C=0, Z=0.
- SUB a=16'h0003, b=16'h0003 -> ans_ex=0, Z=1, C=1. Then AND with fwd_sel_a=1 on a zero result -> Z=1, C stays 1.
- Store: mem_en_rr=1, mem_rw_rr=1, imm_sel_rr=1, a_rr=16'h0003, imm_rr=0, b_rr=16'hFFFF -> ans_ex=16'h0003, DM_data=16'hFFFF, mem_en_ex=1, mem_rw_ex=1.
- MUL 16'h0012 x 16'h0034 (EX_MUL_EN defined) -> stall_ex=1 for 16 cycles, then ans_ex=16'h03A8. The following held ADD completes one cycle after stall_ex drops.
- MUL in flight with reset asserted at busy cycle 5 -> stall_ex=0 and ans_ex=0 at once. Without EX_MUL_EN, the same MUL gives ans_ex=0 after 1 cycle and stall_ex never rises.
